// File: rtl/slike_pkg.sv
// Shared definitions for the laser-harp scan controller: FSM state encoding
// and the countdown timer constants.
package slike_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DARK = 3'd2,
    LIT  = 3'd3,
    EVAL = 3'd4,
    NEXT = 3'd5
  } state_t;

  // Fixed count at which the timer raises 'half'; any dwell must exceed it.
  localparam logic [25:0] HALF_THRESHOLD      = 26'd25000000;
  localparam logic [25:0] DWELL_COUNT_DEFAULT = 26'd50000000;

endpackage

// File: rtl/slike_sync.sv
// Two-flop synchronizer for the asynchronous photodiode comparator outputs.
module slike_sync #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  // Stage 0 captures the raw level, stage 1 resolves metastability.
  always_ff @(posedge clk) begin
    meta_p0 <= d;
    sync_p1 <= meta_p0;
  end

  assign q = sync_p1;

endmodule

// File: rtl/slike_wr.sv
// Laser-harp scan controller. Steps through the strings, runs the countdown
// timer for each dwell, samples ambient (laser off) and lit (laser on)
// photodiode levels, keeps per-string beam-broken flags and pulses note_on
// when a string newly becomes broken.
module slike_wr
  import slike_pkg::*;
#(
  parameter int          NUM_STRINGS = 8,
  parameter int          IDX_W       = 3,
  parameter logic [25:0] DWELL_COUNT = DWELL_COUNT_DEFAULT
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   scan_en,
  input  logic [NUM_STRINGS-1:0] sensor,
  input  logic                   fin,
  input  logic                   half,
  output logic [25:0]            max_count,
  output logic                   countdown,
  output logic                   timer_load,
  output logic [NUM_STRINGS-1:0] laser_en,
  output logic [IDX_W-1:0]       string_idx,
  output logic [NUM_STRINGS-1:0] broken,
  output logic                   note_on,
  output logic [IDX_W-1:0]       note_idx
);

  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_STRINGS - 1);
  localparam logic [NUM_STRINGS-1:0] ONE_HOT0 = NUM_STRINGS'(1);

  state_t                 state;
  logic [NUM_STRINGS-1:0] sync_sensor;
  logic                   ambient;
  logic                   lit;
  logic                   intact;

  assign max_count = DWELL_COUNT;

  // A beam is intact only if light appears with the laser on and is absent
  // with it off; stray ambient light counts as a broken beam.
  assign intact = lit & ~ambient;

  slike_sync #(
    .DATA_W(NUM_STRINGS)
  ) u_sync (
    .clk(CLOCK_50),
    .d  (sensor),
    .q  (sync_sensor)
  );

  // Scan FSM; every output is registered and set for the state being entered.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      string_idx <= '0;
      broken     <= '0;
      laser_en   <= '0;
      note_on    <= 1'b0;
      note_idx   <= '0;
      countdown  <= 1'b0;
      timer_load <= 1'b0;
      ambient    <= 1'b0;
      lit        <= 1'b0;
    end else begin
      note_on    <= 1'b0;
      timer_load <= 1'b0;
      case (state)
        IDLE: begin
          countdown <= 1'b0;
          laser_en  <= '0;
          if (scan_en) begin
            state      <= LOAD;
            countdown  <= 1'b1;
            timer_load <= 1'b1;
          end
        end
        LOAD: begin
          state     <= DARK;
          countdown <= 1'b1;
          laser_en  <= '0;
        end
        DARK: begin
          if (half) begin
            ambient  <= sync_sensor[string_idx];
            laser_en <= ONE_HOT0 << string_idx;
            state    <= LIT;
          end
        end
        LIT: begin
          // 'fin' stays high until countdown drops, so a coincident
          // half/fin is still seen here on the first LIT cycle.
          if (fin) begin
            lit      <= sync_sensor[string_idx];
            laser_en <= '0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          broken[string_idx] <= ~intact;
          if (!broken[string_idx] && !intact) begin
            note_on  <= 1'b1;
            note_idx <= string_idx;
          end
          countdown <= 1'b0;
          state     <= NEXT;
        end
        NEXT: begin
          string_idx <= (string_idx == LAST_IDX) ? '0 : string_idx + 1'b1;
          if (scan_en) begin
            state      <= LOAD;
            countdown  <= 1'b1;
            timer_load <= 1'b1;
          end else begin
            state     <= IDLE;
            countdown <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          countdown <= 1'b0;
          laser_en  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slike_wr.sv
// Bench for slike_wr: timer model, photodiode model driven by a delayed copy
// of the laser drive, per-string scoreboard and scenario table.
module tb_slike_wr;
  import slike_pkg::*;

  logic        clk;
  logic        reset;
  logic        scan_en;
  logic [7:0]  sensor;
  logic        fin;
  logic        half;
  logic [25:0] max_count;
  logic        countdown;
  logic        timer_load;
  logic [7:0]  laser_en;
  logic [2:0]  string_idx;
  logic [7:0]  broken;
  logic        note_on;
  logic [2:0]  note_idx;

  slike_wr #(
    .NUM_STRINGS(8),
    .IDX_W      (3),
    .DWELL_COUNT(26'd20)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .sensor    (sensor),
    .fin       (fin),
    .half      (half),
    .max_count (max_count),
    .countdown (countdown),
    .timer_load(timer_load),
    .laser_en  (laser_en),
    .string_idx(string_idx),
    .broken    (broken),
    .note_on   (note_on),
    .note_idx  (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timer model: registered half/fin, reload on load or countdown low.
  logic [25:0] tcnt;
  logic [25:0] th;
  always @(posedge clk) begin
    if (timer_load || !countdown) begin
      tcnt <= max_count;
      half <= 1'b0;
      fin  <= 1'b0;
    end else begin
      if (tcnt != 0) tcnt <= tcnt - 1'b1;
      half <= (tcnt <= th);
      fin  <= (tcnt == 0);
    end
  end

  // Photodiode model: light follows the laser by two cycles unless blocked
  // or flooded with ambient light.
  logic [7:0] ld1, ld2, blk, amb;
  always @(posedge clk) begin
    ld1 <= laser_en;
    ld2 <= ld1;
  end
  always_comb begin
    sensor = ld2;
    sensor = (sensor & ~blk) | amb;
  end

  // Scoreboard of expected per-string outcomes.
  typedef struct {
    logic [2:0] idx;
    logic       note;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] brk_m;
  logic [2:0] exp_idx;
  logic       coinc;

  task automatic push_string();
    exp_t e;
    logic intact;
    intact = !blk[exp_idx] && !amb[exp_idx] && !coinc;
    e.idx  = exp_idx;
    e.note = !brk_m[exp_idx] && !intact;
    brk_m[exp_idx] = !intact;
    sb.push_back(e);
    exp_idx = exp_idx + 3'd1;
  endtask

  // Monitor: a string is complete when string_idx advances.
  int         done = 0;
  int         tot_notes = 0;
  int         notes_seen = 0;
  logic [2:0] last_note_idx = '0;
  logic [2:0] prev_idx = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_idx   = '0;
      notes_seen = 0;
    end else begin
      if (note_on) begin
        notes_seen++;
        tot_notes++;
        last_note_idx = note_idx;
      end
      if (string_idx != prev_idx) begin
        exp_t e;
        done++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: string %0d completed with no expectation", prev_idx);
        end else begin
          e = sb.pop_front();
          chk("seq_idx", 32'(prev_idx), 32'(e.idx));
          chk("note_count", notes_seen, 32'(e.note));
          if (e.note) chk("note_idx", 32'(last_note_idx), 32'(e.idx));
        end
        notes_seen = 0;
      end
      prev_idx = string_idx;
      chk("laser_onehot", 32'(laser_en),
          (dut.state == LIT) ? 32'(8'd1 << string_idx) : 32'd0);
    end
  end

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: done %0d expected %0d", done, target);
    end
  endtask

  task automatic wait_laser(input int bitn);
    int n;
    n = 0;
    while (!laser_en[bitn] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_laser", 32'(laser_en[bitn]), 32'd1);
  endtask

  typedef struct {
    int         nstr;
    logic [7:0] blk;
    logic [7:0] amb;
    logic [7:0] exp_broken;
    int         exp_notes;
  } row_t;
  row_t tbl[4];

  initial begin
    int base_notes;
    int n;
    tbl[0] = '{8, 8'h08, 8'h20, 8'h28, 2};  // new break on 3, ambient fault on 5
    tbl[1] = '{8, 8'h08, 8'h20, 8'h28, 0};  // still broken: no retrigger
    tbl[2] = '{8, 8'h00, 8'h00, 8'h00, 0};  // all intact, re-arms
    tbl[3] = '{8, 8'h08, 8'h00, 8'h08, 1};  // string 3 breaks again

    reset = 1'b1; scan_en = 1'b0; blk = '0; amb = '0; th = 26'd10; coinc = 1'b0;
    brk_m = '0; exp_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_laser", 32'(laser_en), 0);
    chk("rst_broken", 32'(broken), 0);
    chk("rst_note", 32'(note_on), 0);
    chk("rst_countdown", 32'(countdown), 0);
    chk("rst_load", 32'(timer_load), 0);
    chk("rst_idx", 32'(string_idx), 0);
    chk("max_count", 32'(max_count), 32'd20);

    for (int r = 0; r < 4; r++) begin
      blk = tbl[r].blk;
      amb = tbl[r].amb;
      for (int k = 0; k < tbl[r].nstr; k++) push_string();
      base_notes = tot_notes;
      scan_en = 1'b1;
      wait_done(done + tbl[r].nstr);
      chk("row_broken", 32'(broken), 32'(tbl[r].exp_broken));
      chk("row_notes", tot_notes - base_notes, tbl[r].exp_notes);
    end

    // Reset held three cycles in the middle of LIT.
    blk = '0;
    wait_laser(int'(exp_idx));
    reset = 1'b1;
    scan_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete(); brk_m = '0; exp_idx = '0;
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_idx", 32'(string_idx), 0);
    chk("midrst_laser", 32'(laser_en), 0);
    chk("midrst_broken", 32'(broken), 0);
    chk("midrst_cd", 32'(countdown), 0);
    chk("midrst_load", 32'(timer_load), 0);
    chk("midrst_note", 32'(note_on), 0);

    // Wrap through all strings, stop during LIT of string 1.
    for (int k = 0; k < 10; k++) push_string();
    scan_en = 1'b1;
    wait_done(done + 9);
    wait_laser(1);
    scan_en = 1'b0;
    wait_done(done + 1);
    repeat (3) @(negedge clk);
    chk("stop_state", 32'(dut.state), 32'(IDLE));
    chk("stop_idx", 32'(string_idx), 2);
    chk("stop_cd", 32'(countdown), 0);
    chk("stop_broken", 32'(broken), 0);

    // Coincident half/fin: string 2 ambient-lit, string 3 sampled too early
    // for the laser light to reach the synchronized sensor.
    th = 26'd0; coinc = 1'b1; amb = 8'h04;
    push_string();
    push_string();
    scan_en = 1'b1;
    n = 0;
    while (dut.state != DARK && n < 200) begin @(negedge clk); n++; end
    chk("co_dark", 32'(dut.state), 32'(DARK));
    n = 0;
    while (dut.state == DARK && n < 200) begin @(negedge clk); n++; end
    chk("co_lit", 32'(dut.state), 32'(LIT));
    @(negedge clk);
    chk("co_eval", 32'(dut.state), 32'(EVAL));
    wait_done(done + 1);
    scan_en = 1'b0;
    wait_done(done + 1);
    chk("co_broken", 32'(broken), 32'h0C);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
